// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into imem words and holds the core in reset until loaded
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, WRITE = 2'd2, DONE = 2'd3;
  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
  logic [1:0] state, nxt, idx;
  logic [ADDR_W:0] target, cnt, clamped;
  logic [ADDR_W-1:0] addr;
  logic [23:0] asm_q;
  logic go, accept;
  assign go = start && (state == IDLE || state == DONE);
  assign accept = byte_valid && byte_ready;
  assign clamped = word_count > CAP ? CAP : word_count;
  always_comb begin
    nxt = state;
    if (go) nxt = clamped == '0 ? DONE : LOAD;
    else if (state == LOAD && accept && idx == 2'd3) nxt = WRITE;
    else if (state == WRITE) nxt = cnt + 1'b1 == target ? DONE : LOAD;
  end
  // outputs are registered from the next state so they change together with it
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      byte_ready <= 1'b0;
      imem_we <= 1'b0;
      imem_addr <= '0;
      imem_wdata <= '0;
      cpu_hold <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      idx <= '0;
      cnt <= '0;
      addr <= '0;
      target <= '0;
      asm_q <= '0;
    end else begin
      state <= nxt;
      byte_ready <= nxt == LOAD;
      imem_we <= nxt == WRITE;
      busy <= nxt == LOAD || nxt == WRITE;
      done <= nxt == DONE;
      cpu_hold <= nxt != DONE;
      if (go) begin
        target <= clamped;
        addr <= '0;
        idx <= '0;
        cnt <= '0;
      end
      if (accept) begin
        idx <= idx + 2'd1;
        asm_q <= {asm_q[15:0], byte_data};
        if (idx == 2'd3) begin
          imem_wdata <= {asm_q, byte_data};
          imem_addr <= addr;
        end
      end
      if (state == WRITE) begin
        addr <= addr + 1'b1;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized and directed checks of imem_loader against a word-list reference model
module tb_imem_loader;
  logic clk = 0, reset = 1, start = 0, start2 = 0, byte_valid = 0;
  logic [8:0] word_count = 0;
  logic [2:0] wc2 = 0;
  logic [7:0] byte_data = 0;
  logic byte_ready, imem_we, cpu_hold, busy, done;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata;
  logic byte_ready2, imem_we2, cpu_hold2, busy2, done2;
  logic [1:0] imem_addr2;
  logic [31:0] imem_wdata2;
  int total = 0, bad = 0, viol = 0;
  logic [31:0] wd[$];
  logic [7:0] wa[$];
  logic [31:0] wd2[$];
  logic [1:0] wa2[$];

  imem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done));

  imem_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .word_count(wc2),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready2),
    .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .cpu_hold(cpu_hold2), .busy(busy2), .done(done2));

  always #5 clk = ~clk;

  // write capture plus invariants that must hold on every cycle
  always @(negedge clk) begin
    if (imem_we) begin wd.push_back(imem_wdata); wa.push_back(imem_addr); end
    if (imem_we2) begin wd2.push_back(imem_wdata2); wa2.push_back(imem_addr2); end
    if ((imem_we || done) && byte_ready) viol++;
    if (busy && !imem_we && !byte_ready) viol++;
    if (imem_we && !busy) viol++;
    if (cpu_hold !== !done) viol++;
    if ((imem_we2 || done2) && byte_ready2) viol++;
    if (cpu_hold2 !== !done2) viol++;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int wc);
    byte_valid = 0; start = 1; word_count = 9'(wc);
    tick();
    start = 0;
  endtask

  task automatic feed_byte(input logic [7:0] b, input int stall, input bit two);
    logic acc;
    int n = 0;
    repeat (stall) begin byte_valid = 0; tick(); end
    byte_valid = 1; byte_data = b;
    do begin
      @(negedge clk); acc = two ? byte_ready2 : byte_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 100);
    total++;
    if (!acc) begin bad++; $display("FAIL byte_accept got=timeout exp=accept of %h", b); end
  endtask

  task automatic feed_word(input logic [31:0] w, input int stall, input bit two);
    for (int k = 0; k < 4; k++) feed_byte(w[31-8*k -: 8], stall, two);
  endtask

  task automatic test_reset;
    reset = 1; repeat (2) tick();
    total++; if ({byte_ready, imem_we, cpu_hold, busy, done} !== 5'b00100) begin bad++; $display("FAIL reset_flags got=%b exp=00100", {byte_ready, imem_we, cpu_hold, busy, done}); end
    total++; if (imem_addr !== 8'h0) begin bad++; $display("FAIL reset_addr got=%h exp=00", imem_addr); end
    total++; if (imem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", imem_wdata); end
    reset = 0; tick();
    total++; if ({byte_ready, cpu_hold, done} !== 3'b010) begin bad++; $display("FAIL idle_flags got=%b exp=010", {byte_ready, cpu_hold, done}); end
  endtask

  task automatic test_load2(input int stall);
    logic [31:0] exp_w[2] = '{32'h20080005, 32'h01095020};
    wd.delete(); wa.delete();
    do_start(2);
    feed_word(exp_w[0], stall, 0);
    feed_word(exp_w[1], stall, 0);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL load2_done_early got=%b exp=0", done); end
    tick();
    total++; if ({done, cpu_hold} !== 2'b10) begin bad++; $display("FAIL load2_done got=%b exp=10", {done, cpu_hold}); end
    repeat (3) tick();
    total++; if (wd.size() !== 2) begin bad++; $display("FAIL load2_nwrites got=%0d exp=2", wd.size()); end
    for (int j = 0; j < 2 && j < wd.size(); j++) begin
      total++; if (wd[j] !== exp_w[j] || wa[j] !== 8'(j)) begin bad++; $display("FAIL load2_write%0d got=%h@%h exp=%h@%h", j, wd[j], wa[j], exp_w[j], 8'(j)); end
    end
  endtask

  task automatic test_stall;
    test_load2(3);
    repeat (4) begin
      int wc = $urandom_range(1, 5);
      logic [31:0] words[$];
      wd.delete(); wa.delete();
      do_start(wc);
      for (int j = 0; j < wc; j++) begin
        words.push_back($urandom);
        feed_word(words[j], $urandom_range(0, 3), 0);
      end
      tick();
      total++; if (done !== 1'b1 || wd.size() !== wc) begin bad++; $display("FAIL rand_load got=done%b/%0d exp=done1/%0d", done, wd.size(), wc); end
      for (int j = 0; j < wc && j < wd.size(); j++) begin
        total++; if (wd[j] !== words[j] || wa[j] !== 8'(j)) begin bad++; $display("FAIL rand_write%0d got=%h@%h exp=%h@%h", j, wd[j], wa[j], words[j], 8'(j)); end
      end
    end
  endtask

  task automatic test_zero;
    reset = 1; tick(); reset = 0; tick();
    wd.delete();
    do_start(0);
    total++; if ({done, cpu_hold, busy} !== 3'b100) begin bad++; $display("FAIL zero_done got=%b exp=100", {done, cpu_hold, busy}); end
    repeat (3) tick();
    total++; if (wd.size() !== 0) begin bad++; $display("FAIL zero_nwrites got=%0d exp=0", wd.size()); end
  endtask

  task automatic test_overflow;
    logic [31:0] words[4];
    wd.delete(); wd2.delete(); wa2.delete();
    start2 = 1; wc2 = 3'd7; tick(); start2 = 0;
    for (int j = 0; j < 4; j++) begin words[j] = $urandom; feed_word(words[j], $urandom_range(0, 1), 1); end
    byte_valid = 0; tick();
    total++; if (done2 !== 1'b1 || wd2.size() !== 4) begin bad++; $display("FAIL ovf got=done%b/%0d exp=done1/4", done2, wd2.size()); end
    for (int j = 0; j < 4 && j < wd2.size(); j++) begin
      total++; if (wd2[j] !== words[j] || wa2[j] !== 2'(j)) begin bad++; $display("FAIL ovf_write%0d got=%h@%h exp=%h@%h", j, wd2[j], wa2[j], words[j], 2'(j)); end
    end
    total++; if (wd.size() !== 0) begin bad++; $display("FAIL done_ignores_bytes got=%0d exp=0", wd.size()); end
  endtask

  task automatic test_reset_mid;
    wd.delete(); wa.delete();
    do_start(1);
    feed_byte(8'h12, 0, 0);
    feed_byte(8'h34, 0, 0);
    reset = 1; tick();
    total++; if ({byte_ready, imem_we, cpu_hold, busy, done} !== 5'b00100 || imem_wdata !== 32'h0 || imem_addr !== 8'h0) begin bad++; $display("FAIL midreset got=%b %h %h exp=00100 0 0", {byte_ready, imem_we, cpu_hold, busy, done}, imem_wdata, imem_addr); end
    reset = 0; byte_valid = 0; repeat (2) tick();
    total++; if (wd.size() !== 0) begin bad++; $display("FAIL midreset_nwrites got=%0d exp=0", wd.size()); end
    do_start(1);
    feed_word(32'hDEADBEEF, 0, 0);
    tick();
    total++; if (wd.size() !== 1 || wd[0] !== 32'hDEADBEEF || wa[0] !== 8'h0 || done !== 1'b1) begin bad++; $display("FAIL after_reset got=%0d writes first=%h done=%b exp=1 writes DEADBEEF@00 done=1", wd.size(), wd.size() ? wd[0] : 32'h0, done); end
  endtask

  task automatic test_start_busy;
    logic [31:0] words[3];
    for (int j = 0; j < 3; j++) words[j] = $urandom;
    wd.delete(); wa.delete();
    do_start(3);
    feed_word(words[0], 0, 0);
    feed_byte(words[1][31:24], 0, 0);
    byte_valid = 0; start = 1; word_count = 9'd1; tick(); start = 0;
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL start_busy got=busy%b done%b exp=busy1 done0", busy, done); end
    for (int k = 1; k < 4; k++) feed_byte(words[1][31-8*k -: 8], 1, 0);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL target_kept got=done%b exp=done0", done); end
    feed_word(words[2], 0, 0);
    tick();
    total++; if (done !== 1'b1 || wd.size() !== 3) begin bad++; $display("FAIL busy_load got=done%b/%0d exp=done1/3", done, wd.size()); end
    for (int j = 0; j < 3 && j < wd.size(); j++) begin
      total++; if (wd[j] !== words[j] || wa[j] !== 8'(j)) begin bad++; $display("FAIL busy_write%0d got=%h@%h exp=%h@%h", j, wd[j], wa[j], words[j], 8'(j)); end
    end
    wd.delete(); wa.delete();
    do_start(1);
    total++; if ({cpu_hold, done} !== 2'b10) begin bad++; $display("FAIL reload_hold got=%b exp=10", {cpu_hold, done}); end
    feed_word(32'hFFFFFFFF, 0, 0);
    tick();
    total++; if (wd.size() !== 1 || wd[0] !== 32'hFFFFFFFF || wa[0] !== 8'h0) begin bad++; $display("FAIL reload_write got=%0d first=%h exp=1 FFFFFFFF@00", wd.size(), wd.size() ? wd[0] : 32'h0); end
  endtask

  // byte stream changes every cycle; word j byte k must come from cycle 1+5j+k after start
  task automatic test_ready_write;
    logic [7:0] base = 8'($urandom);
    logic [31:0] e;
    wd.delete(); wa.delete();
    start = 1; word_count = 9'd3; byte_valid = 1; byte_data = base;
    tick();
    start = 0;
    for (int t = 1; t <= 25; t++) begin byte_data = base + 8'(t); tick(); end
    byte_valid = 0; tick();
    total++; if (wd.size() !== 3 || done !== 1'b1) begin bad++; $display("FAIL rw_nwrites got=%0d done%b exp=3 done1", wd.size(), done); end
    for (int j = 0; j < 3 && j < wd.size(); j++) begin
      for (int k = 0; k < 4; k++) e[31-8*k -: 8] = base + 8'(1 + 5*j + k);
      total++; if (wd[j] !== e || wa[j] !== 8'(j)) begin bad++; $display("FAIL rw_write%0d got=%h@%h exp=%h@%h", j, wd[j], wa[j], e, 8'(j)); end
    end
  endtask

  initial begin
    test_reset();
    test_load2(0);
    test_stall();
    test_zero();
    test_overflow();
    test_reset_mid();
    test_start_busy();
    test_ready_write();
    total++; if (viol !== 0) begin bad++; $display("FAIL invariants got=%0d exp=0", viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader that writes the instruction memory read by the processor's fetch stage.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word to consecutive word addresses starting at 0.
- Holds the processor in reset (cpu_hold) until the requested number of words is loaded; sits beside the processor top, driving the imem write port and the core reset.

Parameters:
ADDR_W, 8, instruction memory word-address width; capacity 2^ADDR_W words

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a load; sampled only in IDLE or DONE
word_count  input  ADDR_W+1  number of words to load; latched on accepted start
byte_valid  input  1  byte_data holds a valid byte
byte_data  input  8  program byte, most-significant byte of each word first
byte_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  ADDR_W  word address for imem write
imem_wdata  output  32  assembled instruction word
cpu_hold  output  1  drives processor reset; high while not DONE
busy  output  1  high in LOAD or WRITE
done  output  1  high in DONE; level, not pulse

Behaviour:
- States: IDLE, LOAD, WRITE, DONE; registered state, registered outputs.
- Reset values: state=IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0. Internal byte index=0, word counter=0.
- Reset has priority over every other input, including mid-load. A partial word is discarded and imem is not written.
- IDLE: start=1 latches target = min(word_count, 2^ADDR_W) and clears addr and byte index.
  - target=0: next state DONE.
  - Otherwise: next state LOAD.
- LOAD: byte_ready=1. A byte is accepted when byte_valid&&byte_ready.
  - Byte index k (0..3) is placed in imem_wdata[31-8k -: 8]; index increments on each accepted byte.
  - On the 4th accepted byte: next state WRITE, byte index returns to 0.
  - byte_valid=0 stalls indefinitely with no timeout; held data is unchanged.
- WRITE: exactly one cycle; imem_we=1, imem_addr=current addr, imem_wdata=assembled word; byte_ready=0.
  - Next cycle: addr increments (wraps modulo 2^ADDR_W only after the final write), written count increments.
  - If count==target: next state DONE; otherwise LOAD.
- Latency: the 4th byte is accepted in cycle N; imem_we is high in cycle N+1; byte_ready is high again in cycle N+2.
- DONE: cpu_hold=0, done=1, byte_ready=0. Bytes offered in DONE are ignored.
  - start=1 restarts a load exactly as from IDLE: cpu_hold returns to 1 the next cycle and done drops.
- start is ignored in LOAD and WRITE.
- cpu_hold=1 in IDLE, LOAD and WRITE, so the core never fetches from a partially written memory.
- imem_we is never high outside WRITE. imem_wdata and imem_addr hold their last values outside WRITE.

Test Plan:
- Load 2 words: reset, start with word_count=2, bytes 0x20,0x08,0x00,0x05,0x01,0x09,0x50,0x20 with byte_valid always high.
  - Required: imem_we pulses twice, at addr 0 with data 0x20080005 and at addr 1 with data 0x01095020.
  - Required: done=1 and cpu_hold=0 two cycles after the last byte.
- Stalled stream: same load with byte_valid deasserted 3 cycles between each byte.
  - Required: identical writes and data; byte_ready stays high throughout LOAD; no extra imem_we.
- Zero and overflow counts:
  - word_count=0: DONE the cycle after start, with no imem_we.
  - ADDR_W=2, word_count=7: exactly 4 writes at addr 0..3, then DONE.
- Reset mid-word: reset after 2 bytes of word 0 are accepted.
  - Required: all outputs at reset values, no imem_we, cpu_hold=1.
  - A subsequent full load of 1 word, 0xDEADBEEF, writes addr 0 correctly.
- Start while busy and reload: pulse start during LOAD; it is ignored, with no address reset and target unchanged.
  - After DONE, start with word_count=1: cpu_hold=1 again, addr restarts at 0, and word 0xFFFFFFFF is written to addr 0.
- Ready during WRITE: hold byte_valid=1 continuously.
  - Required: byte_ready=0 in every WRITE cycle and in DONE; no byte is accepted there, verified by the next word's content.
